// File: rtl/opc_bus_pkg.sv
// Shared definitions for the OPC external bus bridge: FSM states,
// address-phase field layout on the uio pads and the abort read value.
package opc_bus_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2,
        DONE = 2'd3
    } bus_state_t;

    localparam int PAD_W   = 8;
    localparam int RNW_BIT = 7;
    localparam int AHI_LSB = 0;

    localparam logic [7:0] TIMEOUT_RDATA = 8'hFF;

    // Builds the uio word shown during the address phase: direction flag on
    // top, high address bits at the bottom, unused bits in between are zero.
    function automatic logic [PAD_W-1:0] addr_phase_word(input logic       rnw,
                                                         input logic [6:0] ahi);
        logic [PAD_W-1:0] word;
        word          = PAD_W'(ahi) << AHI_LSB;
        word[RNW_BIT] = rnw;
        return word;
    endfunction

endpackage

// File: rtl/opc_wait_timer.sv
// Wait-state counter for pad-level handshakes: cleared before a data phase,
// advanced on each stalled cycle, flags when the wait budget is used up.
module opc_wait_timer #(
    parameter int WAIT_MAX = 15,
    parameter int CNT_W    = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    logic [CNT_W-1:0] count;

    // Count stalled cycles; clear takes precedence over counting.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + 1'b1;
        end
    end

    assign expired = (count == CNT_W'(WAIT_MAX));

endmodule

// File: rtl/opc_ext_bus_bridge.sv
// Converts the OPC core's parallel memory bus into a multiplexed, handshaked
// external bus: address low byte on dedicated pads, direction + high address
// and then data time-shared on the bidirectional uio pads.
module opc_ext_bus_bridge
    import opc_bus_pkg::*;
#(
    parameter int ADDR_W   = 11,
    parameter int DATA_W   = 8,
    parameter int WAIT_MAX = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_rnw,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_ack,
    output logic              busy,
    output logic [7:0]        pad_addr_lo,
    output logic [7:0]        pad_io_out,
    output logic [7:0]        pad_io_oe,
    input  logic [7:0]        pad_io_in,
    output logic              pad_ale,
    output logic              pad_ds,
    input  logic              pad_ready,
    input  logic              err_clr,
    output logic              timeout_err
);

    bus_state_t        state;
    logic              rnw_q;
    logic [DATA_W-1:0] wdata_q;
    logic              timer_clear;
    logic              timer_enable;
    logic              timer_expired;

    // The wait budget restarts on the address phase so every data phase gets
    // the full allowance; it only runs while the device holds ready low.
    assign timer_clear  = (state == ADDR);
    assign timer_enable = (state == DATA) && !pad_ready && !timer_expired;

    opc_wait_timer #(
        .WAIT_MAX(WAIT_MAX),
        .CNT_W   (8)
    ) u_wait_timer (
        .clk    (clk),
        .rst    (rst),
        .clear  (timer_clear),
        .enable (timer_enable),
        .expired(timer_expired)
    );

    // Bus sequencer: every pad and CPU-side output is a register updated
    // alongside the state, so the pads never see combinational glitches.
    // The address itself lives in pad_addr_lo/pad_io_out once accepted, so
    // only direction and write data need private copies.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            rnw_q       <= 1'b0;
            wdata_q     <= '0;
            cpu_ack     <= 1'b0;
            cpu_rdata   <= '0;
            busy        <= 1'b0;
            pad_addr_lo <= '0;
            pad_io_out  <= '0;
            pad_io_oe   <= '0;
            pad_ale     <= 1'b0;
            pad_ds      <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            cpu_ack <= 1'b0;
            if (err_clr) begin
                timeout_err <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (cpu_req) begin
                        rnw_q       <= cpu_rnw;
                        wdata_q     <= cpu_wdata;
                        pad_addr_lo <= cpu_addr[7:0];
                        pad_io_out  <= addr_phase_word(cpu_rnw, 7'(cpu_addr[ADDR_W-1:8]));
                        pad_io_oe   <= 8'hFF;
                        pad_ale     <= 1'b1;
                        busy        <= 1'b1;
                        state       <= ADDR;
                    end
                end
                ADDR: begin
                    pad_ale <= 1'b0;
                    pad_ds  <= 1'b1;
                    if (rnw_q) begin
                        pad_io_oe <= 8'h00;
                    end else begin
                        pad_io_out <= 8'(wdata_q);
                        pad_io_oe  <= 8'hFF;
                    end
                    state <= DATA;
                end
                DATA: begin
                    if (pad_ready || timer_expired) begin
                        if (pad_ready) begin
                            if (rnw_q) begin
                                cpu_rdata <= DATA_W'(pad_io_in);
                            end
                        end else begin
                            timeout_err <= 1'b1;
                            if (rnw_q) begin
                                cpu_rdata <= DATA_W'(TIMEOUT_RDATA);
                            end
                        end
                        cpu_ack   <= 1'b1;
                        pad_ds    <= 1'b0;
                        pad_io_oe <= 8'h00;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_opc_ext_bus_bridge.sv
// Self-checking bench for opc_ext_bus_bridge: directed scenarios followed by
// randomized transactions, all compared against a transaction-level model.
module tb_opc_ext_bus_bridge;

    localparam int WAIT_MAX = 15;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_req;
    logic        cpu_rnw;
    logic [10:0] cpu_addr;
    logic [7:0]  cpu_wdata;
    logic [7:0]  cpu_rdata;
    logic        cpu_ack;
    logic        busy;
    logic [7:0]  pad_addr_lo;
    logic [7:0]  pad_io_out;
    logic [7:0]  pad_io_oe;
    logic [7:0]  pad_io_in;
    logic        pad_ale;
    logic        pad_ds;
    logic        pad_ready;
    logic        err_clr;
    logic        timeout_err;

    int          assert_count = 0;
    int          fail_count   = 0;
    int          cyc          = 0;

    // Transaction-level model state: last completed read data and error flag.
    logic [7:0]  model_rdata = 8'h00;
    logic        model_terr  = 1'b0;

    opc_ext_bus_bridge #(
        .ADDR_W  (11),
        .DATA_W  (8),
        .WAIT_MAX(WAIT_MAX)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cpu_req    (cpu_req),
        .cpu_rnw    (cpu_rnw),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_rdata  (cpu_rdata),
        .cpu_ack    (cpu_ack),
        .busy       (busy),
        .pad_addr_lo(pad_addr_lo),
        .pad_io_out (pad_io_out),
        .pad_io_oe  (pad_io_oe),
        .pad_io_in  (pad_io_in),
        .pad_ale    (pad_ale),
        .pad_ds     (pad_ds),
        .pad_ready  (pad_ready),
        .err_clr    (err_clr),
        .timeout_err(timeout_err)
    );

    // Free-running clock and a cycle counter for latency measurements.
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Safety net so a broken design can never stall the run.
    initial begin
        #300000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        assert_count++;
        assert (obs === exp) else begin
            fail_count++;
            $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Runs one complete transaction starting at a negedge in IDLE and ends at
    // the negedge of the ack cycle. Latency, pad phases and results come from
    // the transaction rules, not from watching the design.
    task automatic applyStimulus(input logic rnw, input logic [10:0] addr, input logic [7:0] wdata,
                                 input int waits, input logic [7:0] din, input bit keep_req,
                                 input bit hold_clr, output int ack_cyc);
        bit         tmo;
        int         lat;
        logic       terr_mid;
        logic [7:0] addr_word;
        logic [7:0] data_oe;

        tmo       = (waits > WAIT_MAX);
        lat       = 3 + (tmo ? WAIT_MAX : waits);
        addr_word = 8'((int'(rnw) * 128) + (int'(addr) / 256));
        data_oe   = rnw ? 8'h00 : 8'hFF;
        terr_mid  = hold_clr ? 1'b0 : model_terr;

        checkOutput("idle_busy", 32'(busy), 32'd0);
        checkOutput("idle_ack", 32'(cpu_ack), 32'd0);
        checkOutput("idle_oe", 32'(pad_io_oe), 32'h00);
        checkOutput("idle_ds", 32'(pad_ds), 32'd0);

        cpu_req   = 1'b1;
        cpu_rnw   = rnw;
        cpu_addr  = addr;
        cpu_wdata = wdata;
        pad_ready = 1'b0;
        err_clr   = hold_clr;

        @(negedge clk);
        checkOutput("addr_ale", 32'(pad_ale), 32'd1);
        checkOutput("addr_ds", 32'(pad_ds), 32'd0);
        checkOutput("addr_io_out", 32'(pad_io_out), 32'(addr_word));
        checkOutput("addr_oe", 32'(pad_io_oe), 32'hFF);
        checkOutput("addr_lo", 32'(pad_addr_lo), 32'(addr % 256));
        checkOutput("addr_busy", 32'(busy), 32'd1);
        checkOutput("addr_rdata_hold", 32'(cpu_rdata), 32'(model_rdata));

        // Scramble the CPU side: the bridge must work from its captured copy.
        cpu_rnw   = ~rnw;
        cpu_addr  = 11'($urandom);
        cpu_wdata = 8'($urandom);

        for (int c = 2; c < lat; c++) begin
            @(negedge clk);
            checkOutput("data_ds", 32'(pad_ds), 32'd1);
            checkOutput("data_ale", 32'(pad_ale), 32'd0);
            checkOutput("data_ack", 32'(cpu_ack), 32'd0);
            checkOutput("data_oe", 32'(pad_io_oe), 32'(data_oe));
            checkOutput("data_addr_lo", 32'(pad_addr_lo), 32'(addr % 256));
            checkOutput("data_terr", 32'(timeout_err), 32'(terr_mid));
            if (!rnw) checkOutput("data_wdata", 32'(pad_io_out), 32'(wdata));
            if (c - 2 >= waits) begin
                pad_ready = 1'b1;
                pad_io_in = din;
            end else begin
                pad_ready = 1'b0;
                pad_io_in = 8'($urandom);
            end
        end

        @(negedge clk);
        ack_cyc = cyc;
        if (rnw) model_rdata = tmo ? 8'hFF : din;
        model_terr = tmo ? 1'b1 : terr_mid;
        checkOutput("done_ack", 32'(cpu_ack), 32'd1);
        checkOutput("done_ds", 32'(pad_ds), 32'd0);
        checkOutput("done_oe", 32'(pad_io_oe), 32'h00);
        checkOutput("done_busy", 32'(busy), 32'd1);
        checkOutput("done_rdata", 32'(cpu_rdata), 32'(model_rdata));
        checkOutput("done_terr", 32'(timeout_err), 32'(model_terr));
        checkOutput("done_addr_lo", 32'(pad_addr_lo), 32'(addr % 256));

        pad_ready = 1'b0;
        err_clr   = 1'b0;
        if (!keep_req) cpu_req = 1'b0;
    endtask

    initial begin
        int         a1;
        int         a2;
        int         waits;
        int         sel;
        logic       r;
        logic [10:0] addr;
        logic [7:0] wd;
        logic [7:0] din;
        bit         keep;
        bit         hclr;

        rst       = 1'b1;
        cpu_req   = 1'b0;
        cpu_rnw   = 1'b0;
        cpu_addr  = '0;
        cpu_wdata = '0;
        pad_io_in = '0;
        pad_ready = 1'b0;
        err_clr   = 1'b0;

        // Reset state.
        @(negedge clk);
        @(negedge clk);
        checkOutput("rst_ack", 32'(cpu_ack), 32'd0);
        checkOutput("rst_rdata", 32'(cpu_rdata), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_addr_lo", 32'(pad_addr_lo), 32'd0);
        checkOutput("rst_io_out", 32'(pad_io_out), 32'd0);
        checkOutput("rst_oe", 32'(pad_io_oe), 32'd0);
        checkOutput("rst_ale", 32'(pad_ale), 32'd0);
        checkOutput("rst_ds", 32'(pad_ds), 32'd0);
        checkOutput("rst_terr", 32'(timeout_err), 32'd0);
        rst = 1'b0;

        // Zero-wait write.
        @(negedge clk);
        applyStimulus(1'b0, 11'h123, 8'hA5, 0, 8'h00, 1'b0, 1'b0, a1);

        // Read with two wait states.
        @(negedge clk);
        applyStimulus(1'b1, 11'h7FF, 8'h00, 2, 8'h3C, 1'b0, 1'b0, a1);

        // Read timeout, then clear the sticky error.
        @(negedge clk);
        applyStimulus(1'b1, 11'h055, 8'h00, WAIT_MAX + 1, 8'h11, 1'b0, 1'b0, a1);
        @(negedge clk);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr    = 1'b0;
        model_terr = 1'b0;
        checkOutput("err_clr_clears", 32'(timeout_err), 32'd0);

        // Exactly WAIT_MAX waits still completes normally.
        @(negedge clk);
        applyStimulus(1'b1, 11'h2AA, 8'h00, WAIT_MAX, 8'h69, 1'b0, 1'b0, a1);

        // Write timeout with err_clr held: the set wins, read data untouched.
        @(negedge clk);
        applyStimulus(1'b0, 11'h3C3, 8'h77, WAIT_MAX + 1, 8'h00, 1'b0, 1'b1, a1);

        // Back-to-back with request held high.
        @(negedge clk);
        applyStimulus(1'b0, 11'h100, 8'h5A, 0, 8'h00, 1'b1, 1'b0, a1);
        @(negedge clk);
        applyStimulus(1'b1, 11'h101, 8'h00, 0, 8'hC3, 1'b0, 1'b0, a2);
        checkOutput("b2b_ack_spacing", 32'(a2 - a1), 32'd4);

        // Asynchronous reset in the middle of a data phase.
        @(negedge clk);
        $display("[TB] reset during data phase");
        cpu_req   = 1'b1;
        cpu_rnw   = 1'b0;
        cpu_addr  = 11'h4E7;
        cpu_wdata = 8'h99;
        @(negedge clk);
        @(negedge clk);
        checkOutput("pre_rst_ds", 32'(pad_ds), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("arst_ack", 32'(cpu_ack), 32'd0);
        checkOutput("arst_rdata", 32'(cpu_rdata), 32'd0);
        checkOutput("arst_busy", 32'(busy), 32'd0);
        checkOutput("arst_addr_lo", 32'(pad_addr_lo), 32'd0);
        checkOutput("arst_io_out", 32'(pad_io_out), 32'd0);
        checkOutput("arst_oe", 32'(pad_io_oe), 32'd0);
        checkOutput("arst_ale", 32'(pad_ale), 32'd0);
        checkOutput("arst_ds", 32'(pad_ds), 32'd0);
        checkOutput("arst_terr", 32'(timeout_err), 32'd0);
        cpu_req     = 1'b0;
        model_rdata = 8'h00;
        model_terr  = 1'b0;
        @(negedge clk);
        checkOutput("arst_no_ack", 32'(cpu_ack), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        applyStimulus(1'b1, 11'h0F0, 8'h00, 1, 8'hB4, 1'b0, 1'b0, a1);

        // Randomized transactions.
        for (int i = 0; i < 24; i++) begin
            r    = 1'($urandom_range(0, 1));
            addr = 11'($urandom);
            wd   = 8'($urandom);
            din  = 8'($urandom);
            sel  = int'($urandom_range(0, 9));
            if (sel < 6)      waits = int'($urandom_range(0, 3));
            else if (sel < 8) waits = int'($urandom_range(4, WAIT_MAX));
            else              waits = WAIT_MAX + 1;
            keep = 1'($urandom_range(0, 1));
            hclr = ($urandom_range(0, 7) == 0);
            @(negedge clk);
            applyStimulus(r, addr, wd, waits, din, keep, hclr, a1);
        end
        cpu_req = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checkOutput("final_busy", 32'(busy), 32'd0);
        checkOutput("final_oe", 32'(pad_io_oe), 32'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end

endmodule

// File: doc/opc_ext_bus_bridge.md
Name: opc_ext_bus_bridge

Overview:
Sits directly downstream of the OPC accumulator CPU core. It converts the core's parallel memory bus (11-bit address, 8-bit data, rnw) into a multiplexed, handshaked external bus that fits the Tiny Tapeout pad budget. Address low byte goes to dedicated outputs; address high bits and data share the bidirectional uio pads. The core stalls its FSM while `busy` is high and resumes on `cpu_ack`.

Parameters:
ADDR_W, 11, CPU address width (fixed low byte 8 + high part ADDR_W-8)
DATA_W, 8, data width
WAIT_MAX, 15, max wait-state cycles in DATA before timeout abort (1..255)

Ports:
clk  in  1  single clock, all state on rising edge
rst  in  1  reset, asynchronous, active-high
cpu_req  in  1  CPU requests a bus cycle; held high until cpu_ack
cpu_rnw  in  1  1=read, 0=write
cpu_addr  in  ADDR_W  transaction address
cpu_wdata  in  DATA_W  write data
cpu_rdata  out  DATA_W  read data, valid with cpu_ack, held until next read completes
cpu_ack  out  1  one-cycle completion pulse
busy  out  1  high in any state other than IDLE
pad_addr_lo  out  8  cpu_addr[7:0], held for whole transaction
pad_io_out  out  8  uio output value
pad_io_oe  out  8  uio output enable (1=drive)
pad_io_in  in  8  uio input value
pad_ale  out  1  address-latch strobe
pad_ds  out  1  data strobe
pad_ready  in  1  external device ready (synchronous to clk)
err_clr  in  1  clears timeout_err
timeout_err  out  1  sticky, set on timeout abort

Behaviour:
- Reset (async, any state): state=IDLE; cpu_ack=0, cpu_rdata=0, pad_addr_lo=0, pad_io_out=0, pad_io_oe=0, pad_ale=0, pad_ds=0, timeout_err=0, wait counter=0. A transaction in flight is dropped with no ack.
- All outputs are registered.
- FSM states: IDLE, ADDR, DATA, DONE.
- IDLE: if cpu_req=1, capture rnw/addr/wdata into internal registers and go to ADDR. Otherwise stay.
- ADDR (exactly 1 cycle):
  - pad_ale=1, pad_ds=0.
  - pad_io_out={rnw, 4'b0, addr[10:8]}, pad_io_oe=8'hFF.
  - Next state: DATA; wait counter cleared.
- DATA:
  - pad_ale=0, pad_ds=1.
  - Write: pad_io_out=wdata, oe=8'hFF. Read: oe=8'h00.
  - pad_ready=1: on a read, capture pad_io_in into cpu_rdata; go to DONE.
  - pad_ready=0: increment the wait counter. When the counter equals WAIT_MAX with ready still low, abort: set timeout_err, cpu_rdata=8'hFF on a read (unchanged on a write), go to DONE.
  - Zero-wait case: ready high on the first DATA cycle.
- DONE (1 cycle): cpu_ack=1, pad_ds=0, pad_io_oe=0 (bus turnaround), then IDLE.
  - cpu_req is ignored in DONE. A request still high in the following IDLE starts a new transaction.
- Latency: request seen in IDLE at cycle N gives cpu_ack high at cycle N+3 with zero waits, or N+3+k with k wait cycles.
  - Back-to-back throughput: 1 transaction per 4 cycles.
- pad_io_oe is 8'h00 in IDLE and DONE, so the bus is never driven across transactions.
- timeout_err priority: a set in the same cycle as err_clr wins; otherwise err_clr clears it.
- Changing cpu_addr/wdata/rnw after acceptance has no effect (captured copies are used).

Decomposition:
- Shared package opc_bus_pkg:
  - state enum (IDLE/ADDR/DATA/DONE)
  - ADDR-phase field positions (RNW_BIT=7, AHI_LSB=0)
  - TIMEOUT_RDATA=8'hFF
- One natural sub-module: opc_wait_timer (clear, enable, expired = count==WAIT_MAX), reusable by other pad-level handshakes.
- The top-level wrapper maps pad_addr_lo to uo_out, pad_ready to ui_in[7], and pad_ale/pad_ds to spare ui/uo bits.

Test Plan:
- Write with zero waits: req, rnw=0, addr=11'h123, wdata=8'hA5, ready=1.
  - Expect ADDR cycle: ale=1, io_out=8'h01, oe=FF, addr_lo=8'h23.
  - Expect DATA cycle: ds=1, io_out=A5.
  - Expect ack 3 cycles after req.
- Read with 2 wait states: addr=11'h7FF, ready low for 2 DATA cycles then high with pad_io_in=8'h3C.
  - Expect ADDR io_out=8'h87, oe=00 in DATA.
  - Expect cpu_rdata=3C and ack at N+5.
- Timeout with WAIT_MAX=15 and ready stuck low on a read.
  - Expect ack at N+3+15, rdata=FF, timeout_err=1.
  - err_clr pulse then clears timeout_err to 0.
- Back-to-back: req held high across two transactions (write 0x100, then read 0x101).
  - Expect acks spaced exactly 4 cycles apart.
  - Expect oe=00 in the DONE cycle between them.
- Reset mid-DATA: assert rst asynchronously while ds=1.
  - Expect all outputs zero immediately (before the next clk edge), no ack, busy=0.
  - Expect a new request after reset to complete normally.
